// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus cycle generator.
// RTC_BUS_RECOVERY_EN adds the RECOVERY state to the encoding.
package rtc_bus_pkg;

  localparam int BUS_W           = 8;
  localparam int T_PHASE_DEFAULT = 10;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_ADDR_SETUP  = 4'd1,
    ST_ADDR_STROBE = 4'd2,
    ST_ADDR_HOLD   = 4'd3,
    ST_DATA_SETUP  = 4'd4,
    ST_DATA_STROBE = 4'd5,
    ST_DATA_HOLD   = 4'd6,
`ifdef RTC_BUS_RECOVERY_EN
    ST_RECOVERY    = 4'd7,
`endif
    ST_DONE        = 4'd8
  } state_t;

  // Every state except IDLE and DONE lasts a full phase.
  function automatic logic is_timed(state_t s);
    return !(s == ST_IDLE || s == ST_DONE);
  endfunction

  // A single-cycle phase still needs a one-bit counter.
  function automatic int cnt_width(int t_phase);
    return (t_phase <= 1) ? 1 : $clog2(t_phase);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase counter for the RTC bus FSM: counts 0..T_PHASE-1 and flags the last cycle.
// Clearing has priority over counting.
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int T_PHASE = T_PHASE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  localparam int                 CNT_W = cnt_width(T_PHASE);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(T_PHASE - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign tc = (count_reg == LAST);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle generator for the RTC multiplexed AD port; all outputs registered.
// Optional RECOVERY phase after DATA_HOLD is enabled by RTC_BUS_RECOVERY_EN.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_PHASE = T_PHASE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rw,
  input  logic [BUS_W-1:0] addr,
  input  logic [BUS_W-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [BUS_W-1:0] rdata,
  output logic [BUS_W-1:0] ad_out,
  output logic             ad_oe,
  input  logic [BUS_W-1:0] ad_in,
  output logic             ad_sel,
  output logic             cs_n,
  output logic             rd_n,
  output logic             wr_n
);

  state_t           state_reg, state_next;
  logic             rw_reg, rw_next;
  logic [BUS_W-1:0] addr_reg, addr_next;
  logic [BUS_W-1:0] wdata_reg, wdata_next;
  logic [BUS_W-1:0] rdata_reg, rdata_next;
  logic [BUS_W-1:0] ad_out_reg, ad_out_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             ad_oe_reg, ad_oe_next;
  logic             ad_sel_reg, ad_sel_next;
  logic             cs_n_reg, cs_n_next;
  logic             rd_n_reg, rd_n_next;
  logic             wr_n_reg, wr_n_next;

  logic phase_tc;
  logic phase_clear;

  rtc_phase_timer #(
    .T_PHASE(T_PHASE)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(phase_clear),
    .tc   (phase_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      rw_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      ad_out_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      ad_oe_reg  <= 1'b0;
      ad_sel_reg <= 1'b0;
      cs_n_reg   <= 1'b1;
      rd_n_reg   <= 1'b1;
      wr_n_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      rw_reg     <= rw_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      ad_out_reg <= ad_out_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      ad_oe_reg  <= ad_oe_next;
      ad_sel_reg <= ad_sel_next;
      cs_n_reg   <= cs_n_next;
      rd_n_reg   <= rd_n_next;
      wr_n_reg   <= wr_n_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rw_next    = rw_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          rw_next    = rw;
          addr_next  = addr;
          wdata_next = wdata;
          state_next = ST_ADDR_SETUP;
        end
      end
      ST_ADDR_SETUP:  if (phase_tc) state_next = ST_ADDR_STROBE;
      ST_ADDR_STROBE: if (phase_tc) state_next = ST_ADDR_HOLD;
      ST_ADDR_HOLD:   if (phase_tc) state_next = ST_DATA_SETUP;
      ST_DATA_SETUP:  if (phase_tc) state_next = ST_DATA_STROBE;
      ST_DATA_STROBE: begin
        if (phase_tc) begin
          state_next = ST_DATA_HOLD;
          if (rw_reg) rdata_next = ad_in;
        end
      end
      ST_DATA_HOLD: begin
        if (phase_tc) begin
`ifdef RTC_BUS_RECOVERY_EN
          state_next = ST_RECOVERY;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef RTC_BUS_RECOVERY_EN
      ST_RECOVERY:    if (phase_tc) state_next = ST_DONE;
`endif
      ST_DONE:        state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase

    phase_clear = (state_next != state_reg) || !is_timed(state_reg);

    // Outputs are decoded from the upcoming state so they appear with it.
    ad_out_next = ad_out_reg;
    ad_oe_next  = 1'b0;
    ad_sel_next = 1'b0;
    cs_n_next   = 1'b1;
    rd_n_next   = 1'b1;
    wr_n_next   = 1'b1;
    busy_next   = (state_next != ST_IDLE);
    done_next   = (state_next == ST_DONE);

    case (state_next)
      ST_ADDR_SETUP, ST_ADDR_STROBE, ST_ADDR_HOLD: begin
        cs_n_next   = 1'b0;
        ad_sel_next = 1'b1;
        ad_out_next = addr_next;
        ad_oe_next  = 1'b1;
        wr_n_next   = (state_next != ST_ADDR_STROBE);
      end
      ST_DATA_SETUP, ST_DATA_STROBE, ST_DATA_HOLD: begin
        cs_n_next = 1'b0;
        if (rw_next) begin
          rd_n_next = (state_next != ST_DATA_STROBE);
        end else begin
          ad_out_next = wdata_next;
          ad_oe_next  = 1'b1;
          wr_n_next   = (state_next != ST_DATA_STROBE);
        end
      end
      default: ;
    endcase
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign rdata  = rdata_reg;
  assign ad_out = ad_out_reg;
  assign ad_oe  = ad_oe_reg;
  assign ad_sel = ad_sel_reg;
  assign cs_n   = cs_n_reg;
  assign rd_n   = rd_n_reg;
  assign wr_n   = wr_n_reg;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed, table-driven bench for rtc_bus_ctrl (T_PHASE=4 and T_PHASE=1 instances).
// Expectations follow RTC_BUS_RECOVERY_EN when it is defined.
module tb_rtc_bus_ctrl;
  import rtc_bus_pkg::*;

  localparam int TP = 4;
`ifdef RTC_BUS_RECOVERY_EN
  localparam int REC = 1;
`else
  localparam int REC = 0;
`endif
  localparam int DONE_C = 6*TP + 1 + REC*TP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, rw;
  logic [7:0] addr, wdata, ad_in;
  logic       busy, done, ad_oe, ad_sel, cs_n, rd_n, wr_n;
  logic [7:0] rdata, ad_out;

  logic       start_t1, rw_t1;
  logic [7:0] addr_t1, wdata_t1, ad_in_t1;
  logic       busy_t1, done_t1, ad_oe_t1, ad_sel_t1, cs_n_t1, rd_n_t1, wr_n_t1;
  logic [7:0] rdata_t1, ad_out_t1;

  rtc_bus_ctrl #(.T_PHASE(TP)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .ad_out(ad_out), .ad_oe(ad_oe),
    .ad_in(ad_in), .ad_sel(ad_sel), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n)
  );

  rtc_bus_ctrl #(.T_PHASE(1)) dut_t1 (
    .clk(clk), .reset(reset), .start(start_t1), .rw(rw_t1), .addr(addr_t1), .wdata(wdata_t1),
    .busy(busy_t1), .done(done_t1), .rdata(rdata_t1), .ad_out(ad_out_t1), .ad_oe(ad_oe_t1),
    .ad_in(ad_in_t1), .ad_sel(ad_sel_t1), .cs_n(cs_n_t1), .rd_n(rd_n_t1), .wr_n(wr_n_t1)
  );

  typedef struct packed {
    logic [7:0] ad_out;
    logic       ad_sel, ad_oe, cs_n, rd_n, wr_n, busy, done;
  } obs_t;

  typedef struct {
    logic rw;
    int   lo;
    int   hi;
    logic chk_out;
    obs_t exp;
  } vec_t;

  obs_t obs;
  assign obs = {ad_out, ad_sel, ad_oe, cs_n, rd_n, wr_n, busy, done};

  obs_t cap [1:40];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input int lo, input int hi, input logic co,
                     input logic [7:0] ao, input logic sel, input logic oe, input logic cs,
                     input logic rd, input logic wr, input logic b, input logic d);
    vec_t v;
    v.rw = r; v.lo = lo; v.hi = hi; v.chk_out = co;
    v.exp = {ao, sel, oe, cs, rd, wr, b, d};
    vecs.push_back(v);
  endtask

  // One transaction; cycle c is the c-th edge counting the acceptance edge as 1.
  task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] d,
                         input int ncyc, input int poke_c, input int rst_c);
    @(negedge clk);
    rw = r; addr = a; wdata = d; start = 1'b1; ad_in = 8'hA5;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cap[c] = obs;
      start = 1'b0; rw = ~r; addr = 8'hEE; wdata = 8'hDD;
      ad_in = (c >= 4*TP+1 && c <= 5*TP) ? 8'h59 : 8'hA5;
      if (poke_c != 0 && (c == poke_c || c == poke_c + 8)) begin
        start = 1'b1; addr = 8'h77; wdata = 8'h88;
      end
      if (rst_c != 0 && c == rst_c)     reset = 1'b0;
      if (rst_c != 0 && c == rst_c + 1) reset = 1'b1;
    end
  endtask

  task automatic apply_table(input logic r, input string tag);
    logic [14:0] m;
    foreach (vecs[i]) begin
      if (vecs[i].rw == r) begin
        m = vecs[i].chk_out ? 15'h7fff : 15'h007f;
        for (int c = vecs[i].lo; c <= vecs[i].hi; c++)
          chk($sformatf("%s row%0d cyc%0d", tag, i, c), 32'(cap[c] & m), 32'(vecs[i].exp & m));
      end
    end
  endtask

  initial begin
    int ndone;
    int first_done;

    // Write 0x21/0x45: fields ad_out, sel, oe, cs_n, rd_n, wr_n, busy, done
    add(0,  1,  4, 1, 8'h21, 1, 1, 0, 1, 1, 1, 0);
    add(0,  5,  8, 1, 8'h21, 1, 1, 0, 1, 0, 1, 0);
    add(0,  9, 12, 1, 8'h21, 1, 1, 0, 1, 1, 1, 0);
    add(0, 13, 16, 1, 8'h45, 0, 1, 0, 1, 1, 1, 0);
    add(0, 17, 20, 1, 8'h45, 0, 1, 0, 1, 0, 1, 0);
    add(0, 21, 24, 1, 8'h45, 0, 1, 0, 1, 1, 1, 0);
`ifdef RTC_BUS_RECOVERY_EN
    add(0, 25, 28, 0, 8'h00, 0, 0, 1, 1, 1, 1, 0);
`endif
    add(0, DONE_C, DONE_C, 0, 8'h00, 0, 0, 1, 1, 1, 1, 1);
    add(0, DONE_C+1, DONE_C+2, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0);
    // Read 0x33: bus released and rd_n low in DATA_STROBE
    add(1,  1,  4, 1, 8'h33, 1, 1, 0, 1, 1, 1, 0);
    add(1,  5,  8, 1, 8'h33, 1, 1, 0, 1, 0, 1, 0);
    add(1,  9, 12, 1, 8'h33, 1, 1, 0, 1, 1, 1, 0);
    add(1, 13, 16, 0, 8'h00, 0, 0, 0, 1, 1, 1, 0);
    add(1, 17, 20, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0);
    add(1, 21, 24, 0, 8'h00, 0, 0, 0, 1, 1, 1, 0);
`ifdef RTC_BUS_RECOVERY_EN
    add(1, 25, 28, 0, 8'h00, 0, 0, 1, 1, 1, 1, 0);
`endif
    add(1, DONE_C, DONE_C, 0, 8'h00, 0, 0, 1, 1, 1, 1, 1);
    add(1, DONE_C+1, DONE_C+2, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0);

    reset = 1'b0; start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; ad_in = 8'hA5;
    start_t1 = 1'b0; rw_t1 = 1'b0; addr_t1 = 8'h00; wdata_t1 = 8'h00; ad_in_t1 = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'(obs), 32'(15'b00000000_0_0_1_1_1_0_0));
    chk("reset rdata", 32'(rdata), 32'h0);
    chk("reset t1 busy/cs_n", {30'd0, busy_t1, cs_n_t1}, 32'h1);
    reset = 1'b1;

    run_txn(1'b0, 8'h21, 8'h45, DONE_C+2, 0, 0);
    apply_table(1'b0, "write");
    chk("rdata after write", 32'(rdata), 32'h0);

    run_txn(1'b1, 8'h33, 8'h00, DONE_C+2, 0, 0);
    apply_table(1'b1, "read");
    chk("rdata after read", 32'(rdata), 32'h59);

    // start pulsed while busy must not disturb the latched request
    run_txn(1'b0, 8'h12, 8'h6C, DONE_C+2, 7, 0);
    chk("poke addr held", 32'(cap[9].ad_out), 32'h12);
    chk("poke wdata held", 32'(cap[4*TP+1].ad_out), 32'h6C);
    chk("poke done cycle", 32'(cap[DONE_C].done), 32'h1);
    ndone = 0;
    for (int c = 1; c <= DONE_C+2; c++) ndone += int'(cap[c].done);
    chk("poke done count", 32'(ndone), 32'd1);
    chk("poke rdata kept", 32'(rdata), 32'h59);

    // reset mid-write aborts without a done pulse and clears rdata
    run_txn(1'b0, 8'h21, 8'h45, 40, 0, 10);
    chk("abort cs_n/oe/busy/done", {28'd0, cap[11].cs_n, cap[11].ad_oe, cap[11].busy, cap[11].done},
        32'b1000);
    ndone = 0;
    for (int c = 1; c <= 40; c++) ndone += int'(cap[c].done);
    chk("abort no done", 32'(ndone), 32'd0);
    chk("abort rdata cleared", 32'(rdata), 32'h0);

    run_txn(1'b0, 8'h21, 8'h45, DONE_C+2, 0, 0);
    apply_table(1'b0, "write after abort");

    // T_PHASE=1 read: done 7 cycles after acceptance
    @(negedge clk);
    start_t1 = 1'b1; rw_t1 = 1'b1; addr_t1 = 8'h0F; ad_in_t1 = 8'h3C;
    first_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_t1 = 1'b0;
      if (done_t1 && first_done == 0) first_done = c;
    end
    chk("t1 done cycle", 32'(first_done), 32'(7 + REC));
    chk("t1 rdata", 32'(rdata_t1), 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
